// File: rtl/bram_pkg.sv
// Shared defaults, bank-index width and scheduler state encoding for the BRAM bank scheduler.
package bram_pkg;

    localparam int unsigned NUM_BANKS_DEF = 16;
    localparam int unsigned DEPTH_DEF     = 512;
    localparam int unsigned DATA_W_DEF    = 128;
    localparam int unsigned ADDR_W_DEF    = 9;
    localparam int unsigned BANK_W        = $clog2(NUM_BANKS_DEF);

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_STALL = 1'b1
    } sched_state_e;

endpackage

// File: rtl/bank_ring_ctr.sv
// Modulo-N bank pointer with increment enable.
module bank_ring_ctr
    import bram_pkg::*;
#(
    parameter int unsigned N = NUM_BANKS_DEF,
    parameter int unsigned W = BANK_W
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    // Advance by one, wrapping from N-1 back to 0.
    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = (ptr_q == W'(N - 1)) ? '0 : ptr_q + W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/bram_bank_sched.sv
// Sequences a producer stream into a ring of BRAM banks and hands closed banks to a consumer in order.
module bram_bank_sched
    import bram_pkg::*;
#(
    parameter int unsigned NUM_BANKS = NUM_BANKS_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
    input  logic                           clk_in,
    input  logic                           rst_n,
    input  logic [DATA_W-1:0]              s_data,
    input  logic                           s_valid,
    input  logic                           s_last,
    output logic                           s_ready,
    output logic [DATA_W-1:0]              wr_data,
    output logic [ADDR_W-1:0]              wr_addr,
    output logic [NUM_BANKS-1:0]           wr_en,
    output logic                           rd_valid,
    output logic [$clog2(NUM_BANKS)-1:0]   rd_bank,
    output logic [ADDR_W:0]                rd_len,
    input  logic                           rd_release,
    output logic [$clog2(NUM_BANKS+1)-1:0] occupancy,
    output logic                           release_err
);

    localparam int unsigned BW    = $clog2(NUM_BANKS);
    localparam int unsigned OCC_W = $clog2(NUM_BANKS + 1);
    localparam int unsigned CNT_W = OCC_W + 1;
    localparam int unsigned LEN_W = ADDR_W + 1;

    sched_state_e      state_q, state_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              pend_q, pend_d;
    logic              rel_err_q, rel_err_d;
    logic [NUM_BANKS-1:0] wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [LEN_W-1:0]  len_q [NUM_BANKS];
    logic [LEN_W-1:0]  len_d [NUM_BANKS];

    logic [BW-1:0]     wr_ptr;
    logic [BW-1:0]     rd_ptr;
    logic              accept;
    logic              close;
    logic              rel_acc;
    logic [CNT_W-1:0]  cnt_after;

    assign accept    = s_valid && s_ready;
    assign close     = accept && (s_last || (word_cnt_q == ADDR_W'(DEPTH - 1)));
    assign rel_acc   = rd_release && (occ_q != '0);
    // Closed plus in-flight banks once this cycle's close and release land.
    assign cnt_after = CNT_W'(occ_q) + CNT_W'(pend_q) + CNT_W'(close) - CNT_W'(rel_acc);

    bank_ring_ctr #(.N(NUM_BANKS), .W(BW)) u_wr_ptr (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .inc    (close),
        .ptr    (wr_ptr)
    );

    bank_ring_ctr #(.N(NUM_BANKS), .W(BW)) u_rd_ptr (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .inc    (rel_acc),
        .ptr    (rd_ptr)
    );

    // FSM state register.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Stall once every bank is closed or pending; resume after a release.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL:  if (close && (cnt_after == CNT_W'(NUM_BANKS))) state_d = ST_STALL;
            ST_STALL: if (rel_acc) state_d = ST_FILL;
            default:  state_d = ST_FILL;
        endcase
    end

    // FSM outputs: ready depends on state only.
    always_comb begin
        s_ready = 1'b0;
        if (state_q == ST_FILL) s_ready = 1'b1;
    end

    // Write port, fill counter, bank lengths and publication bookkeeping.
    always_comb begin
        wr_en_d    = '0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        pend_d     = close;
        occ_d      = occ_q + OCC_W'(pend_q) - OCC_W'(rel_acc);
        rel_err_d  = rel_err_q | (rd_release && (occ_q == '0));
        if (accept) begin
            wr_en_d[wr_ptr] = 1'b1;
            wr_addr_d       = word_cnt_q;
            wr_data_d       = s_data;
            if (close) begin
                len_d[wr_ptr] = LEN_W'(word_cnt_q) + LEN_W'(1);
                word_cnt_d    = '0;
            end else begin
                word_cnt_d = word_cnt_q + ADDR_W'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            word_cnt_q <= '0;
            pend_q     <= 1'b0;
            occ_q      <= '0;
            rel_err_q  <= 1'b0;
            for (int i = 0; i < NUM_BANKS; i++) len_q[i] <= '0;
        end else begin
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            word_cnt_q <= word_cnt_d;
            pend_q     <= pend_d;
            occ_q      <= occ_d;
            rel_err_q  <= rel_err_d;
            len_q      <= len_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign occupancy   = occ_q;
    assign rd_valid    = (occ_q != '0);
    assign rd_bank     = rd_ptr;
    assign rd_len      = len_q[rd_ptr];
    assign release_err = rel_err_q;

endmodule

// File: tb/tb_bram_bank_sched.sv
// Scoreboard bench for bram_bank_sched: expected writes queued on acceptance, checked as wr_en pulses appear.
module tb_bram_bank_sched;

    localparam int unsigned NB = 16;
    localparam int unsigned DP = 512;
    localparam int unsigned DW = 128;
    localparam int unsigned AW = 9;

    typedef struct {
        int              bank;
        int              addr;
        logic [DW-1:0]   data;
    } exp_t;

    logic          clk_in = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] wr_addr;
    logic [NB-1:0] wr_en;
    logic          rd_valid;
    logic [3:0]    rd_bank;
    logic [AW:0]   rd_len;
    logic          rd_release;
    logic [4:0]    occupancy;
    logic          release_err;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   m_wr_ptr = 0;
    int   m_cnt = 0;

    bram_bank_sched dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .wr_data     (wr_data),
        .wr_addr     (wr_addr),
        .wr_en       (wr_en),
        .rd_valid    (rd_valid),
        .rd_bank     (rd_bank),
        .rd_len      (rd_len),
        .rd_release  (rd_release),
        .occupancy   (occupancy),
        .release_err (release_err)
    );

    always #5 clk_in = ~clk_in;

    // Write-port monitor: every wr_en pulse must match the oldest queued expectation.
    always @(negedge clk_in) begin
        if (rst_n === 1'b1 && wr_en !== '0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: wr_en=%h addr=%0d with no write expected", wr_en, wr_addr);
            end else begin
                exp_t          e;
                logic [NB-1:0] en;
                e = sb.pop_front();
                en = '0;
                en[e.bank] = 1'b1;
                if (wr_en !== en || wr_addr !== AW'(e.addr) || wr_data !== e.data) begin
                    errors++;
                    $display("FAIL wr_port: got en=%h addr=%0d data=%h, want en=%h addr=%0d data=%h",
                             wr_en, wr_addr, wr_data, en, e.addr, e.data);
                end
            end
        end
    end

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic void accept_model(input logic [DW-1:0] d, input logic last);
        exp_t e;
        e.bank = m_wr_ptr;
        e.addr = m_cnt;
        e.data = d;
        sb.push_back(e);
        if (last || m_cnt == DP - 1) begin
            m_wr_ptr = (m_wr_ptr + 1) % NB;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endfunction

    task automatic send(input logic [DW-1:0] d, input logic last);
        logic rdy;
        bit   done;
        int   n;
        done = 0;
        n = 0;
        s_data = d;
        s_last = last;
        s_valid = 1'b1;
        while (!done) begin
            rdy = s_ready;
            @(posedge clk_in);
            #1;
            if (rdy) begin
                done = 1;
                accept_model(d, last);
            end else if (++n >= 64) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: s_ready=%b after %0d cycles, want 1", s_ready, n);
                s_valid = 1'b0;
                done = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last = 1'b0;
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic release_pulse();
        rd_release = 1'b1;
        @(posedge clk_in);
        #1;
        rd_release = 1'b0;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        s_last = 1'b0;
        rd_release = 1'b0;
        @(negedge clk_in);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expected writes never seen, want 0", sb.size());
        end
        rst_n = 1'b0;
        sb.delete();
        m_wr_ptr = 0;
        m_cnt = 0;
        @(negedge clk_in);
        rst_n = 1'b1;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk_in);
        checks++;
        if (wr_en !== '0 || wr_addr !== '0 || wr_data !== '0 || occupancy !== 5'd0 ||
            rd_valid !== 1'b0 || rd_bank !== 4'd0 || rd_len !== 10'd0 || release_err !== 1'b0 ||
            s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_vals: en=%h addr=%0d data=%h occ=%0d rv=%b bank=%0d len=%0d err=%b rdy=%b, want all 0 and rdy=1",
                     wr_en, wr_addr, wr_data, occupancy, rd_valid, rd_bank, rd_len, release_err, s_ready);
        end
        rst_n = 1'b1;
        idle(2);
        checks++;
        if (wr_en !== '0 || occupancy !== 5'd0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: en=%h occ=%0d rdy=%b, want en=0 occ=0 rdy=1", wr_en, occupancy, s_ready);
        end
    endtask

    task automatic test_full_bank();
        do_reset();
        for (int i = 0; i < DP; i++) send(rand_word(), 1'b0);
        checks++;
        if (occupancy !== 5'd0) begin
            errors++;
            $display("FAIL occ_during_final_write: occupancy=%0d, want 0", occupancy);
        end
        send(rand_word(), 1'b0);
        @(negedge clk_in);
        checks++;
        if (occupancy !== 5'd1 || rd_valid !== 1'b1 || rd_bank !== 4'd0 || rd_len !== 10'd512) begin
            errors++;
            $display("FAIL full_bank_pub: occ=%0d rv=%b bank=%0d len=%0d, want occ=1 rv=1 bank=0 len=512",
                     occupancy, rd_valid, rd_bank, rd_len);
        end
        idle(2);
    endtask

    task automatic test_short_bank();
        do_reset();
        send(rand_word(), 1'b0);
        send(rand_word(), 1'b0);
        send(rand_word(), 1'b1);
        idle(2);
        checks++;
        if (occupancy !== 5'd1 || rd_bank !== 4'd0 || rd_len !== 10'd3) begin
            errors++;
            $display("FAIL short_bank: occ=%0d bank=%0d len=%0d, want occ=1 bank=0 len=3", occupancy, rd_bank, rd_len);
        end
        send(rand_word(), 1'b0);
        idle(2);
    endtask

    task automatic test_last_at_depth();
        do_reset();
        for (int i = 0; i < DP - 1; i++) send(rand_word(), 1'b0);
        send(rand_word(), 1'b1);
        idle(3);
        checks++;
        if (occupancy !== 5'd1 || rd_len !== 10'd512) begin
            errors++;
            $display("FAIL last_at_depth: occ=%0d len=%0d, want occ=1 len=512", occupancy, rd_len);
        end
        send(rand_word(), 1'b0);
        idle(2);
        checks++;
        if (occupancy !== 5'd1) begin
            errors++;
            $display("FAIL last_at_depth_single: occ=%0d, want 1", occupancy);
        end
    endtask

    task automatic test_stall_wrap();
        logic [DW-1:0] held;
        do_reset();
        for (int i = 0; i < NB; i++) send(rand_word(), 1'b1);
        held = rand_word();
        s_data = held;
        s_last = 1'b1;
        s_valid = 1'b1;
        repeat (4) begin
            @(posedge clk_in);
            #1;
        end
        @(negedge clk_in);
        checks++;
        if (occupancy !== 5'd16 || s_ready !== 1'b0 || rd_bank !== 4'd0 || rd_len !== 10'd1) begin
            errors++;
            $display("FAIL stall_full: occ=%0d rdy=%b bank=%0d len=%0d, want occ=16 rdy=0 bank=0 len=1",
                     occupancy, s_ready, rd_bank, rd_len);
        end
        rd_release = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready_early: s_ready=%b during release cycle, want 0", s_ready);
        end
        @(posedge clk_in);
        #1;
        rd_release = 1'b0;
        checks++;
        if (s_ready !== 1'b1 || rd_bank !== 4'd1 || occupancy !== 5'd15) begin
            errors++;
            $display("FAIL stall_release: rdy=%b bank=%0d occ=%0d, want rdy=1 bank=1 occ=15", s_ready, rd_bank, occupancy);
        end
        send(held, 1'b1);
        idle(2);
        checks++;
        if (occupancy !== 5'd16 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL wrap_refill: occ=%0d rdy=%b, want occ=16 rdy=0", occupancy, s_ready);
        end
        for (int k = 0; k < NB; k++) begin
            checks++;
            if (rd_bank !== 4'((k + 1) % NB) || rd_len !== 10'd1 || rd_valid !== 1'b1) begin
                errors++;
                $display("FAIL drain_order[%0d]: bank=%0d len=%0d rv=%b, want bank=%0d len=1 rv=1",
                         k, rd_bank, rd_len, rd_valid, (k + 1) % NB);
            end
            release_pulse();
        end
        checks++;
        if (occupancy !== 5'd0 || rd_valid !== 1'b0 || rd_bank !== 4'd1 || s_ready !== 1'b1 || release_err !== 1'b0) begin
            errors++;
            $display("FAIL drain_end: occ=%0d rv=%b bank=%0d rdy=%b err=%b, want occ=0 rv=0 bank=1 rdy=1 err=0",
                     occupancy, rd_valid, rd_bank, s_ready, release_err);
        end
    endtask

    task automatic test_same_edge();
        do_reset();
        for (int i = 0; i < 3; i++) send(rand_word(), 1'b1);
        idle(2);
        send(rand_word(), 1'b1);
        s_valid = 1'b0;
        s_last = 1'b0;
        checks++;
        if (occupancy !== 5'd3) begin
            errors++;
            $display("FAIL same_edge_pre: occupancy=%0d, want 3", occupancy);
        end
        release_pulse();
        checks++;
        if (occupancy !== 5'd3 || rd_bank !== 4'd1) begin
            errors++;
            $display("FAIL same_edge: occ=%0d bank=%0d, want occ=3 bank=1", occupancy, rd_bank);
        end
        idle(2);
        checks++;
        if (occupancy !== 5'd3) begin
            errors++;
            $display("FAIL same_edge_hold: occupancy=%0d, want 3", occupancy);
        end
    endtask

    task automatic test_release_err();
        do_reset();
        release_pulse();
        checks++;
        if (release_err !== 1'b1 || rd_bank !== 4'd0 || occupancy !== 5'd0) begin
            errors++;
            $display("FAIL release_err_set: err=%b bank=%0d occ=%0d, want err=1 bank=0 occ=0", release_err, rd_bank, occupancy);
        end
        idle(3);
        send(rand_word(), 1'b1);
        idle(2);
        release_pulse();
        checks++;
        if (release_err !== 1'b1 || rd_bank !== 4'd1 || occupancy !== 5'd0) begin
            errors++;
            $display("FAIL release_err_sticky: err=%b bank=%0d occ=%0d, want err=1 bank=1 occ=0", release_err, rd_bank, occupancy);
        end
    endtask

    task automatic test_reset_mid_fill();
        do_reset();
        for (int i = 0; i < 5; i++) send(rand_word(), 1'b1);
        for (int i = 0; i < 200; i++) send(rand_word(), 1'b0);
        s_data = rand_word();
        @(negedge clk_in);
        #2;
        rst_n = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        sb.delete();
        m_wr_ptr = 0;
        m_cnt = 0;
        #1;
        checks++;
        if (wr_en !== '0 || wr_addr !== '0 || wr_data !== '0 || occupancy !== 5'd0 || rd_valid !== 1'b0 ||
            rd_bank !== 4'd0 || rd_len !== 10'd0 || s_ready !== 1'b1 || release_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_vals: en=%h addr=%0d data=%h occ=%0d rv=%b bank=%0d len=%0d rdy=%b err=%b, want all 0 and rdy=1",
                     wr_en, wr_addr, wr_data, occupancy, rd_valid, rd_bank, rd_len, s_ready, release_err);
        end
        @(negedge clk_in);
        rst_n = 1'b1;
        idle(3);
        send(rand_word(), 1'b0);
        idle(2);
        checks++;
        if (occupancy !== 5'd0) begin
            errors++;
            $display("FAIL mid_reset_occ: occupancy=%0d, want 0", occupancy);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        s_data = '0;
        s_valid = 1'b0;
        s_last = 1'b0;
        rd_release = 1'b0;
        test_reset();
        test_full_bank();
        test_short_bank();
        test_last_at_depth();
        test_stall_wrap();
        test_same_edge();
        test_release_err();
        test_reset_mid_fill();
        @(negedge clk_in);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_final: %0d expected writes never seen, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
